// File: rtl/bp_io_cmd_tracker.sv
// bp_io_cmd_tracker: buffers I/O commands, limits uncached I/O in flight,
// and restores tracked command headers onto converter responses.
// Message layout, LSB first: msg_type, addr, size, payload, then data.
module bp_io_cmd_tracker #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 64,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int msg_type_width_p  = 4,
    parameter int size_width_p      = 3,
    parameter int max_outstanding_p = 2,
    localparam int payload_width_lp = lce_id_width_p + $clog2(lce_assoc_p),
    localparam int hdr_width_lp     = msg_type_width_p + paddr_width_p
                                    + size_width_p + payload_width_lp,
    localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_ready_o,

    output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_yumi_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_ready_o,

    output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_ready_i,

    output logic                            error_o
);

    localparam int ptr_width_lp = (max_outstanding_p > 1)
                                ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
    localparam int addr_lsb_lp  = msg_type_width_p;
    localparam int addr_msb_lp  = addr_lsb_lp + paddr_width_p - 1;

    localparam logic [cnt_width_lp-1:0] cnt_max_lp =
        cnt_width_lp'(max_outstanding_p);
    localparam logic [ptr_width_lp-1:0] ptr_last_lp =
        ptr_width_lp'(max_outstanding_p - 1);

    // Tracker pointers wrap at the configured depth, not at a power of 2
    function automatic logic [ptr_width_lp-1:0] f_ptr_next(
        input logic [ptr_width_lp-1:0] p
    );
        return (p == ptr_last_lp) ? '0 : p + 1'b1;
    endfunction

    // Two-entry input buffer
    logic [cce_mem_msg_width_lp-1:0] r_buf [2];
    logic                            r_buf_wptr;
    logic                            r_buf_rptr;
    logic [1:0]                      r_buf_cnt;

    // Header tracker and credit counter
    logic [hdr_width_lp-1:0] r_trk [max_outstanding_p];
    logic [ptr_width_lp-1:0] r_trk_wptr;
    logic [ptr_width_lp-1:0] r_trk_rptr;
    logic [cnt_width_lp-1:0] r_cnt;
    logic                    r_error;

    logic                            w_buf_full;
    logic                            w_buf_empty;
    logic [cce_mem_msg_width_lp-1:0] w_buf_head;
    logic                            w_enq;
    logic                            w_deq;
    logic                            w_credit_ok;
    logic                            w_have_out;
    logic                            w_pop;
    logic [hdr_width_lp-1:0]         w_trk_head;
    logic [paddr_width_p-1:0]        w_resp_addr;
    logic [paddr_width_p-1:0]        w_head_addr;
    logic                            w_addr_mismatch;
    logic                            w_unused;

    assign w_buf_full  = (r_buf_cnt == 2'd2);
    assign w_buf_empty = (r_buf_cnt == 2'd0);
    assign w_buf_head  = r_buf[r_buf_rptr];
    assign w_credit_ok = (r_cnt < cnt_max_lp);
    assign w_have_out  = (r_cnt != '0);

    // Ready is held low while reset is applied, independent of buffer state
    assign io_cmd_ready_o = ~w_buf_full & ~reset_i;
    assign w_enq          = io_cmd_v_i & io_cmd_ready_o;

    assign io_cmd_o   = w_buf_head;
    assign io_cmd_v_o = ~w_buf_empty & w_credit_ok;
    assign w_deq      = io_cmd_yumi_i & io_cmd_v_o;

    assign w_trk_head = r_trk[r_trk_rptr];

    assign io_resp_ready_o = io_resp_ready_i & w_have_out;
    assign io_resp_v_o     = io_resp_v_i & w_have_out;
    assign io_resp_o       = {io_resp_i[cce_mem_msg_width_lp-1:hdr_width_lp],
                              w_trk_head};
    assign w_pop           = io_resp_v_i & io_resp_ready_o;

    // Only the address is compared; the converter regenerates msg_type
    assign w_resp_addr     = io_resp_i[addr_msb_lp:addr_lsb_lp];
    assign w_head_addr     = w_trk_head[addr_msb_lp:addr_lsb_lp];
    assign w_addr_mismatch = (w_resp_addr != w_head_addr);

    assign w_unused = ^{io_resp_i[hdr_width_lp-1:addr_msb_lp+1],
                        io_resp_i[addr_lsb_lp-1:0]};

    assign error_o = r_error;

    // Input buffer storage, written at the tail on accept
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_buf[r_buf_wptr] <= io_cmd_i;
        end
    end

    // Input buffer pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_buf_wptr <= 1'b0;
            r_buf_rptr <= 1'b0;
            r_buf_cnt  <= 2'd0;
        end else begin
            if (w_enq) r_buf_wptr <= ~r_buf_wptr;
            if (w_deq) r_buf_rptr <= ~r_buf_rptr;
            if (w_enq & ~w_deq) begin
                r_buf_cnt <= r_buf_cnt + 2'd1;
            end else if (~w_enq & w_deq) begin
                r_buf_cnt <= r_buf_cnt - 2'd1;
            end
        end
    end

    // Tracker storage records each forwarded header in order
    always_ff @(posedge clk_i) begin
        if (w_deq) begin
            r_trk[r_trk_wptr] <= w_buf_head[hdr_width_lp-1:0];
        end
    end

    // Tracker pointers and credit count; push and pop together cancel
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_trk_wptr <= '0;
            r_trk_rptr <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_deq) r_trk_wptr <= f_ptr_next(r_trk_wptr);
            if (w_pop) r_trk_rptr <= f_ptr_next(r_trk_rptr);
            if (w_deq & ~w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (~w_deq & w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Sticky address-mismatch flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_error <= 1'b0;
        end else if (w_pop & w_addr_mismatch) begin
            r_error <= 1'b1;
        end
    end

endmodule
